multi_player_key_decoder: RTL and testbench

MULTI_PLAYER_KEY_DECODER -- requirements
Module: multi_player_key_decoder

---
 rtl/multi_player_key_decoder_if.sv | 8 +
 rtl/multi_player_key_decoder.sv | 139 +++++++++++++
 tb/tb_multi_player_key_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/multi_player_key_decoder_if.sv
// Receive-side byte bus for multi_player_key_decoder: one UART byte per rx_valid strobe.
interface multi_player_key_decoder_if;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (output rx_data, output rx_valid);
   modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/multi_player_key_decoder.sv
// Decodes UART command bytes into per-player key levels, press pulses, skill and ready state.
// Optional macro KEY_TIMEOUT_EN adds per-player hold timers that drop keys not refreshed in time.
module multi_player_key_decoder #(
   parameter int NUM_PLAYERS  = 2,
   parameter int HOLD_TIMEOUT = 5_000_000
) (
   input  logic                       clk,
   input  logic                       rstn,
   multi_player_key_decoder_if.slave  rx,
   output logic [NUM_PLAYERS*6-1:0]   held,
   output logic [NUM_PLAYERS*6-1:0]   press_pulse,
   output logic [NUM_PLAYERS*2-1:0]   skill_sel,
   output logic [NUM_PLAYERS-1:0]     ready,
   output logic                       game_reset,
   output logic [7:0]                 err_cnt
);

   localparam int HW = NUM_PLAYERS * 6;
   localparam int SW = NUM_PLAYERS * 2;

   if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4 || HOLD_TIMEOUT < 1 || HOLD_TIMEOUT > 16777215) begin : g_bad_param
      $error("multi_player_key_decoder: parameter out of range");
   end

   logic [1:0]          pid_s;
   logic                press_s;
   logic [2:0]          key_s;
   logic [1:0]          val_s;
   logic                pid_ok_s;
   logic                grst_hit_s;
   logic                cmd_ok_s;

   logic [HW-1:0]          held_r,  held_nxt_s;
   logic [HW-1:0]          pulse_r, pulse_nxt_s;
   logic [SW-1:0]          skill_r, skill_nxt_s;
   logic [NUM_PLAYERS-1:0] ready_r, ready_nxt_s;
   logic                   grst_r,  grst_nxt_s;
   logic [7:0]             err_r,   err_nxt_s;

`ifdef KEY_TIMEOUT_EN
   localparam int TW = $clog2(HOLD_TIMEOUT + 1);
   logic [TW-1:0] timer_r     [NUM_PLAYERS];
   logic [TW-1:0] timer_nxt_s [NUM_PLAYERS];
`endif

   assign pid_s      = rx.rx_data[7:6];
   assign press_s    = rx.rx_data[5];
   assign key_s      = rx.rx_data[4:2];
   assign val_s      = rx.rx_data[1:0];
   assign pid_ok_s   = ({1'b0, pid_s} < 3'(NUM_PLAYERS));
   // Game reset is global: it bypasses the pid range check entirely.
   assign grst_hit_s = rx.rx_valid && (key_s == 3'd7) && !press_s;
   assign cmd_ok_s   = rx.rx_valid && pid_ok_s && !grst_hit_s;

   // Next-state decode for one received byte, with optional hold-timer expiry applied first.
   always_comb begin
      held_nxt_s  = held_r;
      pulse_nxt_s = '0;
      skill_nxt_s = skill_r;
      ready_nxt_s = grst_hit_s ? '0 : ready_r;
      grst_nxt_s  = grst_hit_s;
      err_nxt_s   = (rx.rx_valid && !grst_hit_s && !pid_ok_s && (err_r != 8'hFF)) ? (err_r + 8'd1) : err_r;

`ifdef KEY_TIMEOUT_EN
      // Expiry clears first so that a press byte arriving in the same cycle still wins.
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         timer_nxt_s[p] = (timer_r[p] != '0) ? (timer_r[p] - TW'(1)) : '0;
         if (timer_r[p] == TW'(1)) begin
            held_nxt_s[p*6 +: 6] = 6'b000000;
         end else begin
            held_nxt_s[p*6 +: 6] = held_r[p*6 +: 6];
         end
         if (cmd_ok_s && (pid_s == 2'(p)) && press_s && (key_s < 3'd6)) begin
            timer_nxt_s[p] = TW'(HOLD_TIMEOUT);
         end else begin
            timer_nxt_s[p] = timer_nxt_s[p];
         end
      end
`endif

      for (int p = 0; p < NUM_PLAYERS; p++) begin
         for (int k = 0; k < 6; k++) begin
            if (cmd_ok_s && (pid_s == 2'(p)) && (key_s == 3'(k))) begin
               held_nxt_s[p*6+k]  = press_s;
               pulse_nxt_s[p*6+k] = press_s & ~held_r[p*6+k];
            end else begin
               pulse_nxt_s[p*6+k] = 1'b0;
            end
         end
         if (cmd_ok_s && (pid_s == 2'(p)) && (key_s == 3'd6)) begin
            ready_nxt_s[p] = press_s;
         end else begin
            ready_nxt_s[p] = ready_nxt_s[p];
         end
         if (cmd_ok_s && (pid_s == 2'(p)) && (key_s == 3'd7) && press_s) begin
            skill_nxt_s[p*2 +: 2] = val_s;
         end else begin
            skill_nxt_s[p*2 +: 2] = skill_r[p*2 +: 2];
         end
      end
   end

   // State registers; synchronous reset discards any byte presented in the same cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         held_r  <= '0;
         pulse_r <= '0;
         skill_r <= '0;
         ready_r <= '0;
         grst_r  <= 1'b0;
         err_r   <= 8'h00;
`ifdef KEY_TIMEOUT_EN
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            timer_r[p] <= '0;
         end
`endif
      end else begin
         held_r  <= held_nxt_s;
         pulse_r <= pulse_nxt_s;
         skill_r <= skill_nxt_s;
         ready_r <= ready_nxt_s;
         grst_r  <= grst_nxt_s;
         err_r   <= err_nxt_s;
`ifdef KEY_TIMEOUT_EN
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            timer_r[p] <= timer_nxt_s[p];
         end
`endif
      end
   end

   assign held        = held_r;
   assign press_pulse = pulse_r;
   assign skill_sel   = skill_r;
   assign ready       = ready_r;
   assign game_reset  = grst_r;
   assign err_cnt     = err_r;

endmodule

// File: tb/tb_multi_player_key_decoder.sv
// Scoreboard bench for multi_player_key_decoder (2 players, HOLD_TIMEOUT=4) with directed byte vectors.
module tb_multi_player_key_decoder;

   localparam int NP = 2;
   localparam int HT = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   multi_player_key_decoder_if rx_if ();
   logic [NP*6-1:0] held;
   logic [NP*6-1:0] press_pulse;
   logic [NP*2-1:0] skill_sel;
   logic [NP-1:0]   ready;
   logic            game_reset;
   logic [7:0]      err_cnt;

   multi_player_key_decoder #(.NUM_PLAYERS(NP), .HOLD_TIMEOUT(HT)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .rx          (rx_if),
      .held        (held),
      .press_pulse (press_pulse),
      .skill_sel   (skill_sel),
      .ready       (ready),
      .game_reset  (game_reset),
      .err_cnt     (err_cnt)
   );

   typedef struct packed {
      logic [11:0] held;
      logic [11:0] pulse;
      logic [3:0]  skill;
      logic [1:0]  ready;
      logic        grst;
      logic [7:0]  err;
   } exp_t;

   typedef struct {
      exp_t  e;
      int    due;
      string nm;
   } ent_t;

   ent_t sb_q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: outputs are due one cycle after their byte; compare everything that has come due.
   always @(negedge clk) begin
      exp_t act;
      ent_t x;
      act = {held, press_pulse, skill_sel, ready, game_reset, err_cnt};
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         x = sb_q.pop_front();
         n_tests++;
         if (act !== x.e) begin
            n_fail++;
            $display("FAIL %s: got held=%h pulse=%h skill=%b ready=%b grst=%b err=%0d, want held=%h pulse=%h skill=%b ready=%b grst=%b err=%0d",
                     x.nm, act.held, act.pulse, act.skill, act.ready, act.grst, act.err,
                     x.e.held, x.e.pulse, x.e.skill, x.e.ready, x.e.grst, x.e.err);
         end
      end
   end

   task automatic step(input logic r, input logic v, input logic [7:0] d,
                       input logic [11:0] h, input logic [11:0] p, input logic [3:0] s,
                       input logic [1:0] rd, input logic g, input logic [7:0] er, input string nm);
      ent_t x;
      rstn           = r;
      rx_if.rx_valid = v;
      rx_if.rx_data  = d;
      x.e   = {h, p, s, rd, g, er};
      x.due = cyc + 1;
      x.nm  = nm;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'h00;
   endtask

   initial begin
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'h00;
      #1;
      step(1'b0, 1'b0, 8'h00, 12'h000, 12'h000, 4'b0000, 2'b00, 1'b0, 8'd0, "reset");
      step(1'b0, 1'b0, 8'h00, 12'h000, 12'h000, 4'b0000, 2'b00, 1'b0, 8'd0, "reset_hold");
      step(1'b1, 1'b1, 8'h30, 12'h010, 12'h010, 4'b0000, 2'b00, 1'b0, 8'd0, "fire_press");
      step(1'b1, 1'b0, 8'h00, 12'h010, 12'h000, 4'b0000, 2'b00, 1'b0, 8'd0, "pulse_one_cycle");
      step(1'b1, 1'b1, 8'h30, 12'h010, 12'h000, 4'b0000, 2'b00, 1'b0, 8'd0, "repress_no_pulse");
      step(1'b1, 1'b1, 8'h10, 12'h000, 12'h000, 4'b0000, 2'b00, 1'b0, 8'd0, "fire_release");
      step(1'b1, 1'b1, 8'h10, 12'h000, 12'h000, 4'b0000, 2'b00, 1'b0, 8'd0, "release_unheld");
      step(1'b1, 1'b1, 8'h7E, 12'h000, 12'h000, 4'b1000, 2'b00, 1'b0, 8'd0, "skill_p1");
      step(1'b1, 1'b1, 8'h38, 12'h000, 12'h000, 4'b1000, 2'b01, 1'b0, 8'd0, "ready_p0");
      step(1'b1, 1'b1, 8'h1C, 12'h000, 12'h000, 4'b1000, 2'b00, 1'b1, 8'd0, "game_reset");
      step(1'b1, 1'b0, 8'h00, 12'h000, 12'h000, 4'b1000, 2'b00, 1'b0, 8'd0, "grst_one_cycle");
      step(1'b1, 1'b1, 8'h78, 12'h000, 12'h000, 4'b1000, 2'b10, 1'b0, 8'd0, "ready_p1");
      step(1'b1, 1'b1, 8'h58, 12'h000, 12'h000, 4'b1000, 2'b00, 1'b0, 8'd0, "unready_p1");
      step(1'b1, 1'b1, 8'h60, 12'h040, 12'h040, 4'b1000, 2'b00, 1'b0, 8'd0, "p1_up_press");
      step(1'b1, 1'b1, 8'h40, 12'h000, 12'h000, 4'b1000, 2'b00, 1'b0, 8'd0, "p1_up_release");
      step(1'b1, 1'b1, 8'hB0, 12'h000, 12'h000, 4'b1000, 2'b00, 1'b0, 8'd1, "bad_pid");
      for (int i = 2; i <= 300; i++) begin
         step(1'b1, 1'b1, 8'hB0, 12'h000, 12'h000, 4'b1000, 2'b00, 1'b0,
              (i > 255) ? 8'd255 : 8'(i), "err_count");
      end
      step(1'b1, 1'b1, 8'hDC, 12'h000, 12'h000, 4'b1000, 2'b00, 1'b1, 8'd255, "grst_pid3");
      step(1'b1, 1'b1, 8'hFE, 12'h000, 12'h000, 4'b1000, 2'b00, 1'b0, 8'd255, "err_saturated");
      step(1'b1, 1'b1, 8'h30, 12'h010, 12'h010, 4'b1000, 2'b00, 1'b0, 8'd255, "hold_fire");
      step(1'b1, 1'b1, 8'h60, 12'h050, 12'h040, 4'b1000, 2'b00, 1'b0, 8'd255, "hold_p1_up");
      step(1'b0, 1'b1, 8'h38, 12'h000, 12'h000, 4'b0000, 2'b00, 1'b0, 8'd0, "reset_overrides");
      step(1'b1, 1'b1, 8'h38, 12'h000, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "first_after_reset");
`ifdef KEY_TIMEOUT_EN
      step(1'b1, 1'b1, 8'h60, 12'h040, 12'h040, 4'b0000, 2'b01, 1'b0, 8'd0, "to_press");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 8'h00, 12'h040, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "to_still_held");
      step(1'b1, 1'b0, 8'h00, 12'h000, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "to_expired");
      step(1'b1, 1'b1, 8'h60, 12'h040, 12'h040, 4'b0000, 2'b01, 1'b0, 8'd0, "to_press2");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 8'h00, 12'h040, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "to_pre_refresh");
      step(1'b1, 1'b1, 8'h60, 12'h040, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "to_refresh_at_expiry");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 8'h00, 12'h040, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "to_refreshed_held");
      step(1'b1, 1'b0, 8'h00, 12'h000, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "to_refreshed_expired");
      step(1'b1, 1'b1, 8'h60, 12'h040, 12'h040, 4'b0000, 2'b01, 1'b0, 8'd0, "to_press3");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 8'h00, 12'h040, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "to_pre_other");
      step(1'b1, 1'b1, 8'h64, 12'h080, 12'h080, 4'b0000, 2'b01, 1'b0, 8'd0, "to_expiry_press_other");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 8'h00, 12'h080, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "to_other_held");
      step(1'b1, 1'b0, 8'h00, 12'h000, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "to_other_expired");
`else
      step(1'b1, 1'b1, 8'h30, 12'h010, 12'h010, 4'b0000, 2'b01, 1'b0, 8'd0, "nt_press");
      repeat (10000) @(posedge clk);
      #1;
      step(1'b1, 1'b0, 8'h00, 12'h010, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "nt_still_held");
      step(1'b1, 1'b1, 8'h10, 12'h000, 12'h000, 4'b0000, 2'b01, 1'b0, 8'd0, "nt_release");
`endif
      repeat (3) @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d entries unchecked, want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
